// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard, forwarding and flush controller for the in-order
// pipeline. Keeps a shadow copy of each post-decode stage's destination tag.
// From that shadow it produces load-use stalls, per-operand forwarding
// selects and redirect flushes.
//
// Optional build macro: HAZ_PERF_CNT_EN adds 32-bit stall/flush/forward
// event counters (stall_cnt, flush_cnt, fwd_cnt).
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   d_valid             decode stage holds a real instruction
//   d_rs/d_rs_used      source A address and read enable
//   d_rt/d_rt_used      source B address and read enable
//   d_wen/d_waddr       decode destination write enable and address
//   d_is_load           decode instruction is a load
//   ex_redirect         control transfer resolved in REDIRECT_STAGE
//   pc_stall            hold PC                         (combinational)
//   ifid_stall          hold IF/ID                      (combinational)
//   idex_bubble         load NOP into ID/EX             (combinational)
//   ifid_flush          clear IF/ID                     (combinational)
//   idex_flush          clear ID/EX                     (combinational)
//   fwd_a/fwd_b         registered EX operand source: 0 = regfile, k = stage k
//
// SEL_W must satisfy 2**SEL_W > DEPTH so every stage index fits in a select.
module pipe_hazard_ctrl #(
    parameter int unsigned NREG_W         = 4,
    parameter int unsigned DEPTH          = 3,
    parameter int unsigned LOAD_AVAIL     = 3,
    parameter int unsigned ALU_AVAIL      = 2,
    parameter int unsigned REDIRECT_STAGE = 2,
    parameter int unsigned SEL_W          = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic [NREG_W-1:0] d_rs,
    input  logic              d_rs_used,
    input  logic [NREG_W-1:0] d_rt,
    input  logic              d_rt_used,
    input  logic              d_wen,
    input  logic [NREG_W-1:0] d_waddr,
    input  logic              d_is_load,
    input  logic              ex_redirect,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    // Shadow of one post-decode stage.
    typedef struct packed {
        logic              valid;
        logic              wen;
        logic [NREG_W-1:0] waddr;
        logic              is_load;
    } entry_t;

    entry_t ent [1:DEPTH];

    logic [SEL_W:0]   res_a;
    logic [SEL_W:0]   res_b;
    logic             haz_a;
    logic             haz_b;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             hazard;
    logic             issue;

    // Resolve one source operand against the shadow.
    // Returns {unforwardable_hit, select}; the nearest (youngest) match wins
    // because the scan runs oldest-first and later hits overwrite earlier ones.
    function automatic logic [SEL_W:0] resolve(input logic [NREG_W-1:0] src,
                                                input logic              used);
        logic             hit;
        logic             ok;
        logic [SEL_W-1:0] sel;
        int               need;
        hit  = 1'b0;
        ok   = 1'b1;
        sel  = '0;
        need = 0;
        for (int k = int'(DEPTH); k >= 1; k--) begin
            if (used && (src != '0) && ent[k].valid && ent[k].wen &&
                (ent[k].waddr == src)) begin
                hit  = 1'b1;
                need = ent[k].is_load ? int'(LOAD_AVAIL) : int'(ALU_AVAIL);
                // Producer will sit one stage further on once the consumer is in EX.
                ok   = ((k + 1) >= need);
                // Past the last tracked stage the regfile already holds the value.
                sel  = ((k + 1) <= int'(DEPTH)) ? SEL_W'(k + 1) : '0;
            end
        end
        return {hit & ~ok, sel};
    endfunction

    // Per-operand resolution, stall and flush decisions.
    always_comb begin
        res_a  = resolve(d_rs, d_rs_used);
        res_b  = resolve(d_rt, d_rt_used);
        haz_a  = res_a[SEL_W];
        haz_b  = res_b[SEL_W];
        sel_a  = res_a[SEL_W-1:0];
        sel_b  = res_b[SEL_W-1:0];
        hazard = d_valid & (haz_a | haz_b);
        issue  = d_valid & ~hazard & ~ex_redirect;
    end

    // Redirect overrides any stall: the stalled instruction is flushed instead.
    assign pc_stall    = hazard & ~ex_redirect;
    assign ifid_stall  = hazard & ~ex_redirect;
    assign idex_bubble = hazard & ~ex_redirect;
    assign ifid_flush  = ex_redirect;
    assign idex_flush  = ex_redirect;

    // Shadow pipeline; a redirect kills entries younger than the redirecting stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                ent[k] <= '0;
            end
        end else begin
            if (issue) begin
                ent[1] <= '{valid: 1'b1, wen: d_wen, waddr: d_waddr, is_load: d_is_load};
            end else begin
                ent[1] <= '0;
            end
            for (int k = 1; k < int'(DEPTH); k++) begin
                ent[k+1] <= ent[k];
                if (ex_redirect && (k < int'(REDIRECT_STAGE))) begin
                    ent[k+1].valid <= 1'b0;
                end
            end
        end
    end

    // Forwarding selects, valid while the issued instruction is in EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a <= '0;
            fwd_b <= '0;
        end else if (issue) begin
            fwd_a <= sel_a;
            fwd_b <= sel_b;
        end else begin
            fwd_a <= '0;
            fwd_b <= '0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    // Wrapping event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (pc_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (ex_redirect) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
            if (issue && ((sel_a != '0) || (sel_b != '0))) begin
                fwd_cnt <= fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default configuration plus a
// DEPTH=4 / LOAD_AVAIL=4 instance sharing the same stimulus.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       d_valid;
    logic [3:0] d_rs;
    logic       d_rs_used;
    logic [3:0] d_rt;
    logic       d_rt_used;
    logic       d_wen;
    logic [3:0] d_waddr;
    logic       d_is_load;
    logic       ex_redirect;

    logic       pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush;
    logic [1:0] fwd_a, fwd_b;

    logic       pc_stall4, ifid_stall4, idex_bubble4, ifid_flush4, idex_flush4;
    logic [2:0] fwd_a4, fwd_b4;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt, fwd_cnt;
    logic [31:0] stall_cnt4, flush_cnt4, fwd_cnt4;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .d_valid(d_valid),
        .d_rs(d_rs), .d_rs_used(d_rs_used), .d_rt(d_rt), .d_rt_used(d_rt_used),
        .d_wen(d_wen), .d_waddr(d_waddr), .d_is_load(d_is_load),
        .ex_redirect(ex_redirect),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    pipe_hazard_ctrl #(.DEPTH(4), .LOAD_AVAIL(4), .SEL_W(3)) u_dut4 (
        .clk(clk), .rst(rst), .d_valid(d_valid),
        .d_rs(d_rs), .d_rs_used(d_rs_used), .d_rt(d_rt), .d_rt_used(d_rt_used),
        .d_wen(d_wen), .d_waddr(d_waddr), .d_is_load(d_is_load),
        .ex_redirect(ex_redirect),
        .pc_stall(pc_stall4), .ifid_stall(ifid_stall4), .idex_bubble(idex_bubble4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4), .fwd_cnt(fwd_cnt4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive the decode-stage instruction.
    task automatic dec(input logic v, input logic [3:0] rs, input logic rsu,
                       input logic [3:0] rt, input logic rtu, input logic w,
                       input logic [3:0] wa, input logic ld);
        d_valid   = v;
        d_rs      = rs;
        d_rs_used = rsu;
        d_rt      = rt;
        d_rt_used = rtu;
        d_wen     = w;
        d_waddr   = wa;
        d_is_load = ld;
        #1;
    endtask

    // Advance one clock; leave time 1 unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    // Combinational stall triple of the default instance, as one value.
    function automatic logic [31:0] stall3();
        return {29'd0, pc_stall, ifid_stall, idex_bubble};
    endfunction

    initial begin
        rst = 1'b0;
        ex_redirect = 1'b0;
        dec(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        #2;
        check("reset_fwd_a", 32'(fwd_a), 32'd0);
        check("reset_fwd_b", 32'(fwd_b), 32'd0);
        check("reset_stall", stall3(), 32'd0);
        check("reset_flush", {30'd0, ifid_flush, idex_flush}, 32'd0);
        rst = 1'b1;
        step();

        // ALU producer then back-to-back consumer: forward from stage 2.
        dec(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b0);
        check("alu_prod_nostall", stall3(), 32'd0);
        step();
        dec(1'b1, 4'd3, 1'b1, 4'd5, 1'b1, 1'b1, 4'd4, 1'b0);
        check("alu_use_nostall", stall3(), 32'd0);
        check("alu_prod_fwd_a", 32'(fwd_a), 32'd0);
        step();
        check("alu_use_fwd_a", 32'(fwd_a), 32'd2);
        check("alu_use_fwd_b", 32'(fwd_b), 32'd0);
        idle(4);

        // Load-use: one stall cycle, then forward from stage 3 on both operands.
        dec(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
        step();
        dec(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1, 4'd4, 1'b0);
        check("ld_use_stall", stall3(), 32'd7);
        step();
        check("ld_bubble_fwd_a", 32'(fwd_a), 32'd0);
        check("ld_use_stall_end", stall3(), 32'd0);
        step();
        check("ld_use_fwd_a", 32'(fwd_a), 32'd3);
        check("ld_use_fwd_b", 32'(fwd_b), 32'd3);
        idle(4);

        // Load to R0 then read R0: never a hazard.
        dec(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1);
        step();
        dec(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 1'b1, 4'd4, 1'b0);
        check("r0_nostall", stall3(), 32'd0);
        step();
        check("r0_fwd_a", 32'(fwd_a), 32'd0);
        idle(4);

        // Redirect during a load-use stall: flush wins, load shadow killed.
        dec(1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
        step();
        dec(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
        ex_redirect = 1'b1;
        #1;
        check("redir_stall_off", stall3(), 32'd0);
        check("redir_flush", {30'd0, ifid_flush, idex_flush}, 32'd3);
        step();
        ex_redirect = 1'b0;
        #1;
        check("redir_fwd_a", 32'(fwd_a), 32'd0);
        check("redir_killed_nostall", stall3(), 32'd0);
        step();
        check("redir_killed_fwd_a", 32'(fwd_a), 32'd0);
        idle(4);

        // Two producers of R2: nearest wins. Independent operands from stages 2 and 3.
        dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        step();
        dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
        step();
        dec(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
        check("nearest_nostall", stall3(), 32'd0);
        step();
        check("nearest_fwd_a", 32'(fwd_a), 32'd2);
        idle(4);
        dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
        step();
        dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0);
        step();
        dec(1'b1, 4'd7, 1'b1, 4'd6, 1'b1, 1'b1, 4'd8, 1'b0);
        step();
        check("split_fwd_a", 32'(fwd_a), 32'd2);
        check("split_fwd_b", 32'(fwd_b), 32'd3);
        idle(4);

        // DEPTH=4, LOAD_AVAIL=4: load-use stalls for two cycles, then forwards from 4.
        dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
        step();
        dec(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
        check("d4_stall_c1", 32'(pc_stall4), 32'd1);
        step();
        check("d4_stall_c2", 32'(pc_stall4), 32'd1);
        step();
        check("d4_stall_c3", 32'(pc_stall4), 32'd0);
        step();
        check("d4_fwd_a", 32'(fwd_a4), 32'd4);
        idle(5);

        // Reset asserted mid-stall: stall and selects clear immediately.
        dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
        step();
        dec(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
        step();
        dec(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b1, 4'd4, 1'b0);
        check("pre_rst_fwd_a", 32'(fwd_a), 32'd2);
        check("pre_rst_stall", stall3(), 32'd7);
        rst = 1'b0;
        #1;
        check("rst_stall_drop", stall3(), 32'd0);
        check("rst_fwd_a", 32'(fwd_a), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("post_rst_nostall", stall3(), 32'd0);
        step();
        idle(4);

`ifdef HAZ_PERF_CNT_EN
        // Five load-use pairs: one stall cycle and one forwarded issue each.
        for (int p = 0; p < 5; p++) begin
            dec(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
            step();
            dec(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
            step();
            step();
        end
        idle(4);
        check("perf_stall_cnt", stall_cnt, 32'd5);
        check("perf_fwd_cnt", fwd_cnt, 32'd5);
        check("perf_flush_cnt0", flush_cnt, 32'd0);
        ex_redirect = 1'b1;
        step();
        ex_redirect = 1'b0;
        #1;
        check("perf_flush_cnt1", flush_cnt, 32'd1);
        rst = 1'b0;
        #1;
        check("perf_rst_stall_cnt", stall_cnt, 32'd0);
        check("perf_rst_fwd_cnt", fwd_cnt, 32'd0);
        check("perf_rst_flush_cnt", flush_cnt, 32'd0);
        rst = 1'b1;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
